// File: rtl/fir_nsum_pipe_if.sv
// Sample/result bundle for the moving-sum FIR: the producer drives samples,
// the FIR drives the primed sum back.
interface fir_nsum_pipe_if #(
   parameter int W    = 16,
   parameter int TAPS = 8
);
   localparam int LG = $clog2(TAPS);

   logic          clear;
   logic          in_valid;
   logic [W-1:0]  a;
   logic          avg;
   logic          out_valid;
   logic [W+LG-1:0] s;

   modport master (output clear, in_valid, a, avg, input out_valid, s);
   modport slave  (input clear, in_valid, a, avg, output out_valid, s);
endinterface

// File: rtl/fir_nsum_pipe.sv
// N-tap equal-weight moving-sum FIR with a registered pairwise adder tree,
// warm-up gating, optional mean output and synchronous flush.
module fir_nsum_pipe #(
   parameter int W    = 16,
   parameter int TAPS = 8
) (
   input  logic            clk,
   input  logic            reset,
   fir_nsum_pipe_if.slave  bus
);
   localparam int LG = $clog2(TAPS);
   localparam int SW = W + LG;
   localparam logic [LG:0] FULL = (LG+1)'(TAPS);

   if (TAPS < 2 || TAPS > 64 || (TAPS & (TAPS - 1)) != 0) begin : g_bad_taps
      $error("fir_nsum_pipe: TAPS must be a power of two in 2..64");
   end

   function automatic logic [SW-1:0] f_mean(input logic [SW-1:0] sum);
      return sum >> LG;
   endfunction

   logic              w_acc;
   logic              w_prime;
   logic [LG:0]       w_fill_nxt;
   logic [TAPS*W-1:0] w_tap_nxt;
   logic [SW-1:0]     w_sum;

   logic [LG:0]       r_fill;
   logic [TAPS*W-1:0] r_tap;
   logic [LG-1:0]     r_vld_p;
   logic [LG-1:0]     r_avg_p;

   // Stage 0: accept sample, shift taps, decide whether it is primed
   always_comb begin
      w_acc      = bus.in_valid & ~bus.clear;
      w_fill_nxt = (r_fill == FULL) ? FULL : r_fill + 1'b1;
      w_prime    = (w_fill_nxt == FULL);
      w_tap_nxt  = w_acc ? {r_tap[(TAPS-1)*W-1:0], bus.a} : r_tap;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fill  <= '0;
         r_tap   <= '0;
         r_vld_p <= '0;
         r_avg_p <= '0;
      end else begin
         r_avg_p <= (r_avg_p << 1) | LG'(bus.avg);
         if (bus.clear) begin
            r_fill  <= '0;
            r_tap   <= '0;
            r_vld_p <= '0;
         end else begin
            if (w_acc) begin
               r_fill <= w_fill_nxt;
               r_tap  <= w_tap_nxt;
            end
            r_vld_p <= (r_vld_p << 1) | LG'(w_acc & w_prime);
         end
      end
   end

   // Stages 1..LG: level 1 adds pairs of the post-shift taps so the first
   // tree register lands on the same edge that accepts the sample
   for (genvar l = 1; l <= LG; l++) begin : g_lvl
      localparam int NL = TAPS >> l;
      localparam int LW = W + l;

      logic [2*NL*(LW-1)-1:0] w_in;
      logic [NL*LW-1:0]       r_sum;

      if (l == 1) begin : g_first
         assign w_in = w_tap_nxt;
      end else begin : g_next
         assign w_in = g_lvl[l-1].r_sum;
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_sum <= '0;
         end else begin
            for (int j = 0; j < NL; j++) begin
               r_sum[j*LW +: LW] <= {1'b0, w_in[2*j*(LW-1) +: LW-1]}
                                  + {1'b0, w_in[(2*j+1)*(LW-1) +: LW-1]};
            end
         end
      end
   end

   assign w_sum = g_lvl[LG].r_sum;

   // Output stage: s only moves on a primed result, otherwise holds
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.out_valid <= 1'b0;
         bus.s         <= '0;
      end else if (bus.clear) begin
         bus.out_valid <= 1'b0;
         bus.s         <= '0;
      end else begin
         bus.out_valid <= r_vld_p[LG-1];
         if (r_vld_p[LG-1]) begin
            bus.s <= r_avg_p[LG-1] ? f_mean(w_sum) : w_sum;
         end
      end
   end
endmodule

// File: tb/tb_fir_nsum_pipe.sv
// Directed bench for fir_nsum_pipe: a vector table for steady-state sums and
// modes, plus hand sequences for gaps, flush, async reset and a 2-tap build.
module tb_fir_nsum_pipe;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fir_nsum_pipe_if #(.W(16), .TAPS(8)) bus ();
   fir_nsum_pipe_if #(.W(8),  .TAPS(2)) bus2 ();

   fir_nsum_pipe #(.W(16), .TAPS(8)) dut  (.clk(clk), .reset(reset), .bus(bus));
   fir_nsum_pipe #(.W(8),  .TAPS(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic        vld;
      logic [15:0] a;
      logic        avg;
      logic        clr;
      logic        ov;
      logic [18:0] s;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic vld, input logic [15:0] a, input logic avg,
                               input logic clr, input logic ov, input logic [18:0] s);
      vec_t v;
      v.vld = vld; v.a = a; v.avg = avg; v.clr = clr; v.ov = ov; v.s = s;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input logic ov, input logic [18:0] s);
      chk({name, ".out_valid"}, {31'b0, bus.out_valid}, {31'b0, ov});
      chk({name, ".s"}, {13'b0, bus.s}, {13'b0, s});
   endtask

   task automatic chk_out2(input string name, input logic ov, input logic [8:0] s);
      chk({name, ".out_valid"}, {31'b0, bus2.out_valid}, {31'b0, ov});
      chk({name, ".s"}, {23'b0, bus2.s}, {23'b0, s});
   endtask

   task automatic tick(input logic v, input logic [15:0] d, input logic m, input logic c);
      bus.in_valid = v; bus.a = d; bus.avg = m; bus.clear = c;
      @(posedge clk); #1;
   endtask

   task automatic tick2(input logic v, input logic [7:0] d, input logic m);
      bus2.in_valid = v; bus2.a = d; bus2.avg = m; bus2.clear = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      bus.in_valid  = 1'b0; bus.a  = '0; bus.avg  = 1'b0; bus.clear  = 1'b0;
      bus2.in_valid = 1'b0; bus2.a = '0; bus2.avg = 1'b0; bus2.clear = 1'b0;
      reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      chk_out("reset", 1'b0, 19'd0);
      chk_out2("reset2", 1'b0, 9'd0);
      @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;

      // Ramp 1..10, then flush, then all-ones in sum/mean/alternating modes
      for (int i = 0; i < 8; i++) add(1'b1, 16'(i + 1), 1'b0, 1'b0, 1'b0, 19'd0);
      add(1'b1, 16'd9,  1'b0, 1'b0, 1'b0, 19'd0);
      add(1'b1, 16'd10, 1'b0, 1'b0, 1'b0, 19'd0);
      add(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 19'd36);
      add(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 19'd44);
      add(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 19'd52);
      add(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 19'd0);
      for (int i = 0; i < 8; i++) add(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 19'd0);
      add(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 19'd0);
      add(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 19'd0);
      add(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 19'h7FFF8);
      for (int i = 0; i < 5; i++) add(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 19'h0FFFF);
      add(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 19'h0FFFF);
      add(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 19'h0FFFF);
      add(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 19'h0FFFF);
      add(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 19'h7FFF8);
      add(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 19'h0FFFF);
      add(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 19'h7FFF8);
      add(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 19'h0FFFF);
      add(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 19'h0FFFF);

      foreach (vecs[i]) begin
         tick(vecs[i].vld, vecs[i].a, vecs[i].avg, vecs[i].clr);
         chk_out($sformatf("vec%0d", i), vecs[i].ov, vecs[i].s);
      end

      // Gapped primed stream of 100s
      tick(1'b0, 16'd0, 1'b0, 1'b1);
      chk_out("gap.clear", 1'b0, 19'd0);
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, 16'd100, 1'b0, 1'b0);
         chk_out($sformatf("gap.fill%0d", i), 1'b0, 19'd0);
      end
      tick(1'b0, 16'd0, 1'b0, 1'b0); chk_out("gap.lat1", 1'b0, 19'd0);
      tick(1'b0, 16'd0, 1'b0, 1'b0); chk_out("gap.lat2", 1'b0, 19'd0);
      tick(1'b0, 16'd0, 1'b0, 1'b0); chk_out("gap.first", 1'b1, 19'd800);
      for (int r = 0; r < 4; r++) begin
         tick(1'b1, 16'd100, 1'b0, 1'b0);
         chk_out($sformatf("gap.s%0d", r), (r > 0), 19'd800);
         tick(1'b0, 16'd0, 1'b0, 1'b0);
         chk_out($sformatf("gap.i%0da", r), 1'b0, 19'd800);
         tick(1'b0, 16'd0, 1'b0, 1'b0);
         chk_out($sformatf("gap.i%0db", r), 1'b0, 19'd800);
      end
      tick(1'b0, 16'd0, 1'b0, 1'b0); chk_out("gap.last", 1'b1, 19'd800);
      tick(1'b0, 16'd0, 1'b0, 1'b0); chk_out("gap.after", 1'b0, 19'd800);

      // Flush with two results in flight and a sample on the clear edge
      tick(1'b1, 16'd7, 1'b0, 1'b0); chk_out("flush.pre1", 1'b0, 19'd800);
      tick(1'b1, 16'd9, 1'b0, 1'b0); chk_out("flush.pre2", 1'b0, 19'd800);
      tick(1'b1, 16'd5, 1'b0, 1'b1); chk_out("flush.edge", 1'b0, 19'd0);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 16'd0, 1'b0, 1'b0);
         chk_out($sformatf("flush.drain%0d", i), 1'b0, 19'd0);
      end
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, 16'(11 + i), 1'b0, 1'b0);
         chk_out($sformatf("flush.refill%0d", i), 1'b0, 19'd0);
      end
      tick(1'b0, 16'd0, 1'b0, 1'b0); chk_out("flush.lat1", 1'b0, 19'd0);
      tick(1'b0, 16'd0, 1'b0, 1'b0); chk_out("flush.lat2", 1'b0, 19'd0);
      tick(1'b0, 16'd0, 1'b0, 1'b0); chk_out("flush.sum", 1'b1, 19'd116);

      // Asynchronous reset between edges with samples in flight
      tick(1'b1, 16'd20, 1'b0, 1'b0); chk_out("arst.pre1", 1'b0, 19'd116);
      tick(1'b1, 16'd21, 1'b0, 1'b0); chk_out("arst.pre2", 1'b0, 19'd116);
      #2 reset = 1'b0;
      #1;
      chk_out("arst.now", 1'b0, 19'd0);
      bus.in_valid = 1'b0;
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      chk_out("arst.rel", 1'b0, 19'd0);
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, 16'd3, 1'b0, 1'b0);
         chk_out($sformatf("arst.fill%0d", i), 1'b0, 19'd0);
      end
      tick(1'b0, 16'd0, 1'b0, 1'b0); chk_out("arst.lat1", 1'b0, 19'd0);
      tick(1'b0, 16'd0, 1'b0, 1'b0); chk_out("arst.lat2", 1'b0, 19'd0);
      tick(1'b0, 16'd0, 1'b0, 1'b0); chk_out("arst.sum", 1'b1, 19'd24);

      // Two-tap, 8-bit build
      tick2(1'b1, 8'd5, 1'b0);   chk_out2("t2.a5", 1'b0, 9'd0);
      tick2(1'b1, 8'd7, 1'b0);   chk_out2("t2.a7", 1'b0, 9'd0);
      tick2(1'b0, 8'd0, 1'b0);   chk_out2("t2.sum12", 1'b1, 9'd12);
      tick2(1'b1, 8'd5, 1'b1);   chk_out2("t2.a5avg", 1'b0, 9'd12);
      tick2(1'b0, 8'd0, 1'b0);   chk_out2("t2.mean6", 1'b1, 9'd6);
      tick2(1'b1, 8'd255, 1'b0); chk_out2("t2.ff1", 1'b0, 9'd6);
      tick2(1'b1, 8'd255, 1'b0); chk_out2("t2.sum260", 1'b1, 9'd260);
      tick2(1'b0, 8'd0, 1'b0);   chk_out2("t2.sum510", 1'b1, 9'd510);
      tick2(1'b0, 8'd0, 1'b0);   chk_out2("t2.hold", 1'b0, 9'd510);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
